versatile_io_wb_bridge: RTL and testbench

- Upstream neighbour of the versatile_io slave block.
- Accepts pipelined Wishbone B4 requests from the system bus (stall/ack handshake).
- Replays each request as a single classic Wishbone B3 cycle toward the io peripherals (UART etc.), then returns the read data and ack.
- A watchdog terminates cycles that no peripheral acknowledges and reports an error, so a bad address cannot hang the bus.

---
 rtl/versatile_io_wb_bridge_if.sv | 26 ++
 rtl/versatile_io_wb_bridge.sv | 100 ++++++++++
 tb/tb_versatile_io_wb_bridge.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/versatile_io_wb_bridge_if.sv
// rtl/versatile_io_wb_bridge_if.sv - Wishbone bus bundle shared by the system side and the io side of the bridge
interface versatile_io_wb_bridge_if #(
    parameter int adr_width = 32,
    parameter int dat_width = 32
) ();
    logic [adr_width-1:0]   adr;
    logic [dat_width-1:0]   wdat;
    logic [dat_width-1:0]   rdat;
    logic [dat_width/8-1:0] sel;
    logic                   we;
    logic                   stb;
    logic                   cyc;
    logic                   ack;
    logic                   err;
    logic                   stall;

    modport master (
        output adr, wdat, sel, we, stb, cyc,
        input  rdat, ack, err, stall
    );

    modport slave (
        input  adr, wdat, sel, we, stb, cyc,
        output rdat, ack, err, stall
    );
endinterface

// File: rtl/versatile_io_wb_bridge.sv
// rtl/versatile_io_wb_bridge.sv - Pipelined Wishbone B4 slave replaying each request as one classic cycle with a watchdog
module versatile_io_wb_bridge #(
    parameter int adr_width = 32,
    parameter int dat_width = 32,
    parameter int timeout   = 64
) (
    input  logic                           wbs_clk,
    input  logic                           wbs_rst,
    versatile_io_wb_bridge_if.slave        wbs,
    versatile_io_wb_bridge_if.master       wbm
);

    localparam int cnt_w = (timeout > 2) ? $clog2(timeout) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [cnt_w-1:0]       cnt;
    logic [adr_width-1:0]   adr_q;
    logic [dat_width-1:0]   wdat_q;
    logic [dat_width/8-1:0] sel_q;
    logic                   we_q;
    logic [dat_width-1:0]   rdat_q;
    logic                   ack_pend;
    logic                   err_pend;

    always_ff @(posedge wbs_clk) begin
        if (wbs_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            rdat_q   <= '0;
            ack_pend <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_pend <= 1'b0;
                    err_pend <= 1'b0;
                    rdat_q   <= '0;
                    if (wbs.cyc && wbs.stb) begin
                        adr_q  <= wbs.adr;
                        wdat_q <= wbs.wdat;
                        sel_q  <= wbs.sel;
                        we_q   <= wbs.we;
                        cnt    <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // The master abandoning its cycle takes priority: nobody is left to answer.
                    if (!wbs.cyc) begin
                        state <= IDLE;
                    end else if (wbm.ack) begin
                        rdat_q   <= we_q ? '0 : wbm.rdat;
                        ack_pend <= 1'b1;
                        state    <= RESP;
                    end else if (cnt == cnt_last) begin
                        rdat_q   <= '0;
                        err_pend <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    ack_pend <= 1'b0;
                    err_pend <= 1'b0;
                    rdat_q   <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response pulses are gated by cyc so a master that leaves during RESP sees nothing.
    assign wbs.ack   = ack_pend && wbs.cyc;
    assign wbs.err   = err_pend && !ack_pend && wbs.cyc;
    assign wbs.rdat  = (ack_pend && wbs.cyc) ? rdat_q : '0;
    assign wbs.stall = (state != IDLE);

    assign wbm.cyc  = (state == REQ);
    assign wbm.stb  = (state == REQ);
    assign wbm.adr  = adr_q;
    assign wbm.wdat = wdat_q;
    assign wbm.sel  = sel_q;
    assign wbm.we   = we_q;

endmodule

// File: tb/tb_versatile_io_wb_bridge.sv
// tb/tb_versatile_io_wb_bridge.sv - Scoreboard bench for versatile_io_wb_bridge
module tb_versatile_io_wb_bridge;

    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t exp_q[$];

    versatile_io_wb_bridge_if #(.adr_width(32), .dat_width(32)) wbs ();
    versatile_io_wb_bridge_if #(.adr_width(32), .dat_width(32)) wbm ();

    versatile_io_wb_bridge #(
        .adr_width(32),
        .dat_width(32),
        .timeout  (TIMEOUT)
    ) dut (
        .wbs_clk(clk),
        .wbs_rst(rst),
        .wbs    (wbs),
        .wbm    (wbm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (wbs.ack || wbs.err)) begin
            resp_t e;
            check("ack_err_exclusive", 64'(wbs.ack & wbs.err), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b dat=%h expected none",
                         wbs.ack, wbs.err, wbs.rdat);
            end else begin
                e = exp_q.pop_front();
                check("resp_ack", 64'(wbs.ack), 64'(e.ack));
                check("resp_err", 64'(wbs.err), 64'(e.err));
                check("resp_dat", 64'(wbs.rdat), 64'(e.dat));
            end
        end
    end

    // ack_at: REQ cycle in which the io slave acks (0 = never); drop_at: REQ cycle in which the master drops cyc (0 = never)
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [31:0] rdat,
                        input int ack_at, input int drop_at);
        int  j;
        int  cyc_hi;
        int  exp_hi;
        bit  done;
        @(posedge clk); #1;
        wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = we;
        wbs.adr = adr; wbs.wdat = wdat; wbs.sel = sel;
        if (drop_at == 0) begin
            if (ack_at > 0) exp_q.push_back({1'b1, 1'b0, (we ? 32'd0 : rdat)});
            else            exp_q.push_back({1'b0, 1'b1, 32'd0});
        end
        exp_hi = (drop_at > 0) ? drop_at : ((ack_at > 0) ? ack_at : TIMEOUT);
        @(posedge clk); #1;
        wbs.stb = 1'b0;
        wbs.wdat = 32'hFFFF_FFFF;
        cyc_hi = 0; j = 1; done = 0;
        while (!done) begin
            if (wbm.cyc) cyc_hi++;
            check("req_stb", 64'(wbm.stb), 64'd1);
            check("req_stall", 64'(wbs.stall), 64'd1);
            check("req_adr", 64'(wbm.adr), 64'(adr));
            check("req_we", 64'(wbm.we), 64'(we));
            check("req_sel", 64'(wbm.sel), 64'(sel));
            check("req_wdat", 64'(wbm.wdat), 64'(wdat));
            if (j == drop_at) wbs.cyc = 1'b0;
            if (j == ack_at) begin
                wbm.ack = 1'b1;
                wbm.rdat = rdat;
            end
            @(posedge clk); #1;
            wbm.ack = 1'b0;
            wbm.rdat = 32'hBAD0_BAD0;
            if (j == drop_at || j == ack_at || j == TIMEOUT) done = 1;
            j++;
        end
        check("cyc_high_cycles", 64'(cyc_hi), 64'(exp_hi));
        check("post_cyc", 64'(wbm.cyc), 64'd0);
        if (drop_at > 0) begin
            check("abort_stall", 64'(wbs.stall), 64'd0);
        end else begin
            check("resp_stall", 64'(wbs.stall), 64'd1);
            @(posedge clk); #1;
            check("idle_stall", 64'(wbs.stall), 64'd0);
        end
        wbs.cyc = 1'b0;
    endtask

    initial begin
        logic [31:0] b_adr [3];
        logic [31:0] b_dat [3];
        b_adr[0] = 32'h0000_0100; b_adr[1] = 32'h0000_0104; b_adr[2] = 32'h0000_0108;
        b_dat[0] = 32'h1111_0001; b_dat[1] = 32'h2222_0002; b_dat[2] = 32'h3333_0003;

        wbs.cyc = 0; wbs.stb = 0; wbs.we = 0; wbs.adr = '0; wbs.wdat = '0; wbs.sel = '0;
        wbm.ack = 0; wbm.rdat = '0; wbm.err = 0; wbm.stall = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_stall", 64'(wbs.stall), 64'd0);
        check("rst_ack", 64'(wbs.ack), 64'd0);
        check("rst_err", 64'(wbs.err), 64'd0);
        check("rst_dat", 64'(wbs.rdat), 64'd0);
        check("rst_wbm_cyc", 64'(wbm.cyc), 64'd0);
        check("rst_wbm_stb", 64'(wbm.stb), 64'd0);
        check("rst_wbm_adr", 64'(wbm.adr), 64'd0);

        xfer(1'b0, 32'h0000_0003, 32'd0, 4'hF, 32'h4141_4141, 1, 0);
        xfer(1'b1, 32'h0000_0010, 32'h0000_5A00, 4'b0010, 32'hDEAD_BEEF, 3, 0);
        xfer(1'b0, 32'h0000_0020, 32'd0, 4'hF, 32'h0, 0, 0);
        xfer(1'b0, 32'h0000_0024, 32'd0, 4'hF, 32'h7E57_0042, 2, 0);
        xfer(1'b0, 32'h0000_0028, 32'd0, 4'hF, 32'hCAFE_F00D, TIMEOUT, 0);
        xfer(1'b0, 32'h0000_002C, 32'd0, 4'hF, 32'h5555_AAAA, 0, 2);

        // reset pulse while the io cycle is in flight
        @(posedge clk); #1;
        wbs.cyc = 1; wbs.stb = 1; wbs.we = 1; wbs.adr = 32'h0000_0030;
        wbs.wdat = 32'h1234_5678; wbs.sel = 4'hF;
        @(posedge clk); #1;
        wbs.stb = 0;
        check("pre_rst_cyc", 64'(wbm.cyc), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_stall", 64'(wbs.stall), 64'd0);
        check("mid_rst_cyc", 64'(wbm.cyc), 64'd0);
        check("mid_rst_stb", 64'(wbm.stb), 64'd0);
        check("mid_rst_adr", 64'(wbm.adr), 64'd0);
        check("mid_rst_wdat", 64'(wbm.wdat), 64'd0);
        check("mid_rst_we", 64'(wbm.we), 64'd0);
        check("mid_rst_ack", 64'(wbs.ack), 64'd0);
        wbs.cyc = 0; wbs.we = 0;

        xfer(1'b0, 32'h0000_0034, 32'd0, 4'hF, 32'h0BAD_C0DE, 1, 0);

        // back-to-back reads with stb held high while stalled
        @(posedge clk); #1;
        wbs.cyc = 1; wbs.stb = 1; wbs.we = 0; wbs.sel = 4'hF; wbs.adr = b_adr[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("b2b_adr", 64'(wbm.adr), 64'(b_adr[i]));
            check("b2b_stb", 64'(wbm.stb), 64'd1);
            if (i < 2) wbs.adr = b_adr[i+1];
            else       wbs.stb = 0;
            wbm.ack = 1; wbm.rdat = b_dat[i];
            exp_q.push_back({1'b1, 1'b0, b_dat[i]});
            @(posedge clk); #1;
            wbm.ack = 0; wbm.rdat = 32'hBAD0_BAD0;
            check("b2b_resp_stall", 64'(wbs.stall), 64'd1);
            @(posedge clk); #1;
            check("b2b_idle_stall", 64'(wbs.stall), 64'd0);
        end
        wbs.cyc = 0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
